mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Timing: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 in_op  in  4  op code: 0 pass, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as pass.
REQ-006 in_addr  in  32  effective byte address.
REQ-007 in_data  in  32  store data, or ALU result for a pass op.
REQ-008 in_rd  in  5  destination register.
REQ-009 in_rd_we  in  1  instruction writes rd.
REQ-010 in_ready  out  1  accept strobe; an instruction is accepted on an edge where in_valid=1 and in_ready=1.
REQ-011 mem_req / mem_we  out  1 / 1  byte access request / write enable.
REQ-012 mem_addr / mem_wdata  out  32 / 8  byte address / byte write data.
REQ-013 mem_ready / mem_rdata  in  1 / 8  byte access completes this cycle / read byte, valid while mem_ready=1.
REQ-014 wb_flag / wb_address / wb_data  out  1 / 5 / 32  registered write-back to regfile.
REQ-015 misalign_err  out  1  one-cycle alignment fault pulse; exists only with MISALIGN_CHECK_EN.

Function
REQ-016 FSM states: IDLE, ACCESS. in_ready=1 exactly when state=IDLE.
REQ-017 IDLE, pass op accepted: next cycle wb_flag=in_rd_we&&(in_rd!=0), wb_address=in_rd, wb_data=in_data; state stays IDLE (1-cycle latency, back-to-back capable).
REQ-018 IDLE, load/store accepted: latch op, addr, data, rd; byte index=0; go to ACCESS.
REQ-019 Byte count: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
REQ-020 In ACCESS: mem_req=1, mem_addr=base+index (32-bit modulo, 0xFFFFFFFF wraps to 0), mem_we=1 for stores, mem_wdata=store byte[index].
REQ-021 Each edge with mem_ready=1: capture mem_rdata into result byte[index] for loads; increment index; a mem_ready=0 edge holds all ACCESS state (unbounded wait).
REQ-022 Edge completing the last byte: go to IDLE; next cycle loads drive wb_flag=(rd!=0) with the assembled data; stores drive wb_flag=0.
REQ-023 Byte order little-endian; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-024 Zero-wait memory: LW accepted at edge N -> mem_req cycles N+1..N+4 -> wb_flag high in cycle N+5, when in_ready=1 again.
REQ-025 wb_flag is a one-cycle pulse per instruction; whenever wb_flag=0, wb_address=0 and wb_data=0.
REQ-026 Regardless of in_rd_we, rd=0 never asserts wb_flag.
REQ-027 in_valid while in_ready=0 is ignored; upstream holds its inputs.
REQ-028 mem_req is never asserted in IDLE; mem_rdata is ignored when mem_req=0.

Reset
REQ-029 rst=0 forces immediately, asynchronously: state IDLE, index 0, and all latched fields 0.
REQ-030 rst=0 forces immediately, asynchronously, on outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wb_flag=0, wb_address=0, wb_data=0, misalign_err=0.
REQ-031 Reset during ACCESS aborts the transfer: no write-back, and stores already completed are not undone.
REQ-032 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro MISALIGN_CHECK_EN: when defined, an accepted LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no memory access and no write-back, stays IDLE, and pulses misalign_err next cycle.
REQ-034 When MISALIGN_CHECK_EN is undefined, misalign_err is absent and every address is serviced byte-wise per REQ-020.

Verification
REQ-035 Pass op, rd=5, data 0x1234_5678, rd_we=1 -> next cycle wb_flag=1, wb_address=5, wb_data=0x12345678; following idle cycle -> wb_flag=0, wb_address=0, wb_data=0.
REQ-036 SW addr 0x100 data 0xA1B2C3D4, mem_ready=1 -> bytes D4,C3,B2,A1 to 0x100-0x103 over 4 cycles; then LW 0x100 -> wb_data=0xA1B2C3D4 five cycles after accept.
REQ-037 LB/LBU of byte 0x80 -> wb_data 0xFFFFFF80 / 0x00000080; LH of bytes 0x34,0xF2 -> 0xFFFFF234.
REQ-038 LW with mem_ready low 3 cycles on byte 2 -> mem_addr held, in_ready=0 throughout, correct wb_data after 7 ACCESS cycles; LB to rd=0 -> wb_flag stays 0.
REQ-039 Reset asserted on byte 1 of SW -> mem_req drops within the same cycle, no wb_flag; LB accepted on the first edge after release completes normally.
REQ-040 MISALIGN_CHECK_EN defined: LW addr 0x102 -> misalign_err=1 one cycle, mem_req=0; undefined: LW addr 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/mem_access.sv
// MEM stage: pass ops write back in one cycle; loads/stores are serialised onto a byte-wide port.
// Define MISALIGN_CHECK_EN to reject misaligned halfword/word accesses with a misalign_err pulse.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_we,
  output logic        in_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        wb_flag,
  output logic [4:0]  wb_address,
  output logic [31:0] wb_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [31:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'd0, raw[7:0]};
      OP_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return a != 2'd0;
      default:              return 1'b0;
    endcase
  endfunction
`endif

  state_t      state_q;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [4:0]  rd_q;
  logic [1:0]  idx_q;
  logic [31:0] result_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [7:0]  mem_wdata_q;
  logic        wb_flag_q;
  logic [4:0]  wb_address_q;
  logic [31:0] wb_data_q;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_q;
`endif

  logic [31:0] raw_d;
  logic [31:0] load_val_d;
  logic [1:0]  idx_d;
  logic        fault_d;

  // Merge the byte arriving this cycle into the partially assembled load word.
  always_comb begin
    raw_d = result_q;
    case (idx_q)
      2'd0:    raw_d[7:0]   = mem_rdata;
      2'd1:    raw_d[15:8]  = mem_rdata;
      2'd2:    raw_d[23:16] = mem_rdata;
      default: raw_d[31:24] = mem_rdata;
    endcase
  end

  assign idx_d      = idx_q + 2'd1;
  assign load_val_d = load_ext(op_q, raw_d);

`ifdef MISALIGN_CHECK_EN
  assign fault_d = misaligned(in_op, in_addr[1:0]);
`else
  assign fault_d = 1'b0;
`endif

  // Control FSM; every output is a register so reset clears them without delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      addr_q       <= 32'd0;
      data_q       <= 32'd0;
      rd_q         <= 5'd0;
      idx_q        <= 2'd0;
      result_q     <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 8'd0;
      wb_flag_q    <= 1'b0;
      wb_address_q <= 5'd0;
      wb_data_q    <= 32'd0;
`ifdef MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      wb_flag_q    <= 1'b0;
      wb_address_q <= 5'd0;
      wb_data_q    <= 32'd0;
`ifdef MISALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if ((is_load(in_op) || is_store(in_op)) && !fault_d) begin
              state_q     <= ACCESS;
              op_q        <= in_op;
              addr_q      <= in_addr;
              data_q      <= in_data;
              rd_q        <= in_rd;
              idx_q       <= 2'd0;
              result_q    <= 32'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store(in_op);
              mem_addr_q  <= in_addr;
              mem_wdata_q <= in_data[7:0];
            end else if (is_load(in_op) || is_store(in_op)) begin
`ifdef MISALIGN_CHECK_EN
              misalign_q  <= 1'b1;
`endif
            end else if (in_rd_we && (in_rd != 5'd0)) begin
              wb_flag_q    <= 1'b1;
              wb_address_q <= in_rd;
              wb_data_q    <= in_data;
            end
          end
        end
        ACCESS: begin
          // mem_ready low simply holds every field, so waits are unbounded.
          if (mem_ready) begin
            if (is_load(op_q)) begin
              result_q <= raw_d;
            end
            if (idx_q == last_idx(op_q)) begin
              state_q     <= IDLE;
              idx_q       <= 2'd0;
              mem_req_q   <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= 32'd0;
              mem_wdata_q <= 8'd0;
              if (is_load(op_q) && (rd_q != 5'd0)) begin
                wb_flag_q    <= 1'b1;
                wb_address_q <= rd_q;
                wb_data_q    <= load_val_d;
              end
            end else begin
              idx_q       <= idx_d;
              mem_addr_q  <= addr_q + {30'd0, idx_d};
              mem_wdata_q <= byte_sel(data_q, idx_d);
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wb_flag    = wb_flag_q;
  assign wb_address = wb_address_q;
  assign wb_data    = wb_data_q;
`ifdef MISALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule
